// File: rtl/rgb_pkg.sv
// Shared colour-code definitions for the RGB PWM controller: 3-bit colour codes,
// their {R,G,B} drive patterns, and the decode function used by every channel.
package rgb_pkg;

  typedef enum logic [2:0] {
    COL_RED     = 3'b000,
    COL_MAGENTA = 3'b001,
    COL_YELLOW  = 3'b010,
    COL_GREEN   = 3'b011,
    COL_CYAN    = 3'b100,
    COL_BLUE    = 3'b101,
    COL_WHITE   = 3'b110,
    COL_OFF     = 3'b111
  } color_e;

  // Drive patterns, bit order {R,G,B}, active-high.
  localparam logic [2:0] RGB_RED     = 3'b100;
  localparam logic [2:0] RGB_MAGENTA = 3'b101;
  localparam logic [2:0] RGB_YELLOW  = 3'b110;
  localparam logic [2:0] RGB_GREEN   = 3'b010;
  localparam logic [2:0] RGB_CYAN    = 3'b011;
  localparam logic [2:0] RGB_BLUE    = 3'b001;
  localparam logic [2:0] RGB_WHITE   = 3'b111;
  localparam logic [2:0] RGB_NONE    = 3'b000;

  function automatic logic [2:0] decode_color(input color_e code);
    case (code)
      COL_RED:     return RGB_RED;
      COL_MAGENTA: return RGB_MAGENTA;
      COL_YELLOW:  return RGB_YELLOW;
      COL_GREEN:   return RGB_GREEN;
      COL_CYAN:    return RGB_CYAN;
      COL_BLUE:    return RGB_BLUE;
      COL_WHITE:   return RGB_WHITE;
      default:     return RGB_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// One RGB LED channel: duty compare against the shared PWM counter, colour decode,
// blink gating and the registered LED drive.
module rgb_pwm_chan
  import rgb_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic [2:0]       color,
  input  logic [PWM_W-1:0] duty,
  input  logic             blink,
  input  logic             blink_on,
  output logic [2:0]       rgb
);

  logic en;
  logic gate;

  assign en   = (pwm_cnt < duty);
  assign gate = ~blink | blink_on;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb <= RGB_NONE;
    end else begin
      rgb <= decode_color(color_e'(color)) & {3{en & gate}};
    end
  end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Multi-LED RGB PWM controller: shared prescaler/PWM timebase, double-buffered
// settings applied at period wrap. Optional blinking enabled by RGB_PWM_BLINK_EN.
module rgb_pwm_ctrl
  import rgb_pkg::*;
#(
  parameter int N_LED     = 2,
  parameter int PWM_W     = 8,
  parameter int PRESC     = 125,
  parameter int BLINK_PER = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3*N_LED-1:0]     color_i,
  input  logic [PWM_W*N_LED-1:0] duty_i,
  input  logic [N_LED-1:0]       blink_i,
  input  logic                   load_i,
  output logic                   load_ack_o,
  output logic                   period_o,
  output logic [3*N_LED-1:0]     rgb_o
);

  localparam int                 PRESC_W   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC - 1);
  localparam logic [PWM_W-1:0]   PWM_MAX   = '1;

  logic [PRESC_W-1:0]     presc_cnt;
  logic [PWM_W-1:0]       pwm_cnt;
  logic                   tick;
  logic                   wrap;

  logic                   pend_flag;
  logic [3*N_LED-1:0]     pend_color, act_color;
  logic [PWM_W*N_LED-1:0] pend_duty,  act_duty;
  logic [N_LED-1:0]       led_blink;
  logic                   blink_on;

  assign tick     = (presc_cnt == PRESC_MAX);
  assign wrap     = tick && (pwm_cnt == PWM_MAX);
  assign period_o = wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Pending values are applied before a coincident load overwrites them, so a
  // load landing in the wrap cycle waits for the following wrap.
  // NOTE: the pending value registers are reset too; they are plain flops, not a
  // memory, and a defined value keeps a never-loaded pending set harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_flag  <= 1'b0;
      pend_color <= {N_LED{COL_OFF}};
      pend_duty  <= '0;
      act_color  <= {N_LED{COL_OFF}};
      act_duty   <= '0;
      load_ack_o <= 1'b0;
    end else begin
      load_ack_o <= wrap && pend_flag;
      if (wrap && pend_flag) begin
        act_color <= pend_color;
        act_duty  <= pend_duty;
      end
      if (load_i) begin
        pend_color <= color_i;
        pend_duty  <= duty_i;
        pend_flag  <= 1'b1;
      end else if (wrap) begin
        pend_flag  <= 1'b0;
      end
    end
  end

`ifdef RGB_PWM_BLINK_EN
  localparam int                 BLINK_W   = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_PER - 1);

  logic [N_LED-1:0]   pend_blink, act_blink;
  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_blink <= '0;
      act_blink  <= '0;
    end else begin
      if (wrap && pend_flag) act_blink  <= pend_blink;
      if (load_i)            pend_blink <= blink_i;
    end
  end

  // Half-phase counter advances once per PWM period; phase starts lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (wrap) begin
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign led_blink = act_blink;
`else
  logic unused_blink;

  assign unused_blink = (^blink_i) ^ (BLINK_PER > 0);
  assign led_blink    = '0;
  assign blink_on     = 1'b1;
`endif

  for (genvar k = 0; k < N_LED; k++) begin : g_led
    rgb_pwm_chan #(
      .PWM_W (PWM_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .pwm_cnt  (pwm_cnt),
      .color    (act_color[3*k +: 3]),
      .duty     (act_duty[PWM_W*k +: PWM_W]),
      .blink    (led_blink[k]),
      .blink_on (blink_on),
      .rgb      (rgb_o[3*k +: 3])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Self-checking bench for rgb_pwm_ctrl (N_LED=2, PWM_W=4, PRESC=2, BLINK_PER=2):
// a cycle model pushes expected outputs to a queue, popped at each falling edge.
module tb_rgb_pwm_ctrl;

  localparam int N       = 2;
  localparam int PW      = 4;
  localparam int PRESC   = 2;
  localparam int BPER    = 2;
  localparam int LEVELS  = 1 << PW;
  localparam int PER_CLK = PRESC * LEVELS;
`ifdef RGB_PWM_BLINK_EN
  localparam int BLINK_LIT = 60;
`else
  localparam int BLINK_LIT = 120;
`endif

  localparam logic [2:0] DEC [8] = '{3'b100, 3'b101, 3'b110, 3'b010,
                                     3'b011, 3'b001, 3'b111, 3'b000};

  typedef struct {
    logic [3*N-1:0] rgb;
    logic           per;
    logic           ack;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [3*N-1:0]  color_i;
  logic [PW*N-1:0] duty_i;
  logic [N-1:0]    blink_i;
  logic            load_i;
  logic            load_ack_o;
  logic            period_o;
  logic [3*N-1:0]  rgb_o;

  rgb_pwm_ctrl #(
    .N_LED     (N),
    .PWM_W     (PW),
    .PRESC     (PRESC),
    .BLINK_PER (BPER)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .color_i    (color_i),
    .duty_i     (duty_i),
    .blink_i    (blink_i),
    .load_i     (load_i),
    .load_ack_o (load_ack_o),
    .period_o   (period_o),
    .rgb_o      (rgb_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  int       m_cyc;
  logic     m_pend;
  logic [2:0] m_act_col [N], m_pend_col [N];
  int       m_act_duty [N], m_pend_duty [N];
  logic     m_act_blk [N],  m_pend_blk [N];

  int cnt0, cnt1, ack_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_cyc  = 0;
    m_pend = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_act_col[k]  = 3'b111;
      m_act_duty[k] = 0;
      m_act_blk[k]  = 1'b0;
    end
    q.delete();
  endtask

  // One clock: model the edge ending cycle m_cyc, then compare the next cycle.
  task automatic step();
    exp_t e;
    int   c, pwm_c;
    bit   wrap_c, on_c, lit;
    @(posedge clk);
    c      = m_cyc;
    wrap_c = (c % PER_CLK) == PER_CLK - 1;
    pwm_c  = (c / PRESC) % LEVELS;
`ifdef RGB_PWM_BLINK_EN
    on_c   = (((c / PER_CLK) / BPER) % 2) == 0;
`else
    on_c   = 1'b1;
`endif
    for (int k = 0; k < N; k++) begin
      lit = (pwm_c < m_act_duty[k]) && (!m_act_blk[k] || on_c);
      e.rgb[3*k +: 3] = lit ? DEC[m_act_col[k]] : 3'b000;
    end
    e.per = ((c + 1) % PER_CLK) == PER_CLK - 1;
    e.ack = wrap_c && m_pend;
    q.push_back(e);
    if (wrap_c && m_pend) begin
      m_act_col  = m_pend_col;
      m_act_duty = m_pend_duty;
      m_act_blk  = m_pend_blk;
    end
    if (load_i) begin
      for (int k = 0; k < N; k++) begin
        m_pend_col[k]  = color_i[3*k +: 3];
        m_pend_duty[k] = int'(duty_i[PW*k +: PW]);
        m_pend_blk[k]  = blink_i[k];
      end
      m_pend = 1'b1;
    end else if (wrap_c) begin
      m_pend = 1'b0;
    end
    m_cyc++;
    @(negedge clk);
    if (q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check("rgb_o", 32'(rgb_o), 32'(e.rgb));
      check("period_o", 32'(period_o), 32'(e.per));
      check("load_ack_o", 32'(load_ack_o), 32'(e.ack));
    end
    cnt0     += (rgb_o[2:0] != 3'b000) ? 1 : 0;
    cnt1     += (rgb_o[5:3] != 3'b000) ? 1 : 0;
    ack_seen += load_ack_o ? 1 : 0;
  endtask

  task automatic do_load(input logic [3*N-1:0] col, input logic [PW*N-1:0] duty,
                         input logic [N-1:0] blk);
    color_i = col;
    duty_i  = duty;
    blink_i = blk;
    load_i  = 1'b1;
    step();
    load_i  = 1'b0;
  endtask

  task automatic go_to(input int pos);
    while ((m_cyc % PER_CLK) != pos) step();
  endtask

  task automatic measure(input int n);
    cnt0 = 0;
    cnt1 = 0;
    repeat (n) step();
  endtask

  task automatic release_reset();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_rgb", 32'(rgb_o), 32'd0);
    check("rst_period", 32'(period_o), 32'd0);
    check("rst_ack", 32'(load_ack_o), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    color_i  = '0;
    duty_i   = '0;
    blink_i  = '0;
    load_i   = 1'b0;
    cnt0     = 0;
    cnt1     = 0;
    ack_seen = 0;
    release_reset();

    // Nothing loaded: dark outputs, period pulse every PER_CLK cycles.
    repeat (70) step();

    // LED0 white at duty 4, LED1 off.
    go_to(10);
    do_load({3'b111, 3'b110}, {4'd0, 4'd4}, 2'b00);
    repeat (40) step();
    measure(PER_CLK);
    check("duty4_led0_lit", 32'(cnt0), 32'd8);
    check("duty4_led1_lit", 32'(cnt1), 32'd0);

    // Extremes: LED0 duty 0, LED1 green at full duty.
    do_load({3'b011, 3'b000}, {4'd15, 4'd0}, 2'b00);
    repeat (50) step();
    measure(PER_CLK);
    check("duty0_led0_lit", 32'(cnt0), 32'd0);
    check("duty15_led1_lit", 32'(cnt1), 32'd30);

    // Two loads in one period: single ack, last values active.
    go_to(5);
    ack_seen = 0;
    do_load({3'b100, 3'b101}, {4'd9, 4'd7}, 2'b00);
    repeat (5) step();
    do_load({3'b001, 3'b010}, {4'd12, 4'd3}, 2'b00);
    repeat (40) step();
    check("double_load_acks", 32'(ack_seen), 32'd1);

    // Load pending, then another load in the wrap cycle itself.
    go_to(20);
    do_load({3'b110, 3'b000}, {4'd2, 4'd14}, 2'b00);
    go_to(PER_CLK - 1);
    do_load({3'b000, 3'b110}, {4'd6, 4'd10}, 2'b00);
    repeat (70) step();

    // Blink on LED0 only, both at full duty.
    go_to(8);
    do_load({3'b001, 3'b110}, {4'd15, 4'd15}, 2'b01);
    repeat (40) step();
    measure(4 * PER_CLK);
    check("blink_led0_lit", 32'(cnt0), 32'(BLINK_LIT));
    check("blink_led1_lit", 32'(cnt1), 32'd120);

    // Async reset mid-period with a load pending.
    go_to(12);
    do_load({3'b101, 3'b011}, {4'd5, 4'd5}, 2'b00);
    repeat (3) step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rgb", 32'(rgb_o), 32'd0);
    check("async_rst_ack", 32'(load_ack_o), 32'd0);
    check("async_rst_period", 32'(period_o), 32'd0);
    release_reset();
    ack_seen = 0;
    repeat (80) step();
    check("no_ack_after_reset", 32'(ack_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_ctrl.md
RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
REQ-001 SHALL have parameter N_LED, default 2, meaning number of RGB LEDs driven.
REQ-002 SHALL have parameter PWM_W, default 8, meaning PWM counter and duty width in bits.
REQ-003 SHALL have parameter PRESC, default 125, meaning clk cycles per PWM tick (>=1).
REQ-004 SHALL have parameter BLINK_PER, default 64, meaning PWM periods per blink half-phase (>=1).
REQ-005 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port color_i  input  3*N_LED  per-LED colour code; LED k at [3k+2:3k].
REQ-008 SHALL have port duty_i  input  PWM_W*N_LED  per-LED brightness; LED k at [PWM_W*k +: PWM_W].
REQ-009 SHALL have port blink_i  input  N_LED  per-LED blink enable.
REQ-010 SHALL have port load_i  input  1  single-cycle strobe capturing color_i/duty_i/blink_i into pending registers.
REQ-011 SHALL have port load_ack_o  output  1  one-cycle pulse when pending settings become active.
REQ-012 SHALL have port period_o  output  1  one-cycle pulse at each PWM period wrap.
REQ-013 SHALL have port rgb_o  output  3*N_LED  LED drive, active-high, LED k as {R,G,B} at [3k+2:3k].

Function
REQ-014 SHALL decode colour code to {R,G,B}: 000→100, 001→101, 010→110, 011→010, 100→011, 101→001, 110→111, 111→000.
REQ-015 SHALL run a prescaler 0..PRESC-1, asserting internal tick in the cycle it equals PRESC-1, then wrapping to 0.
REQ-016 SHALL increment a PWM_W-bit counter on each tick, wrapping from 2^PWM_W-1 to 0; wrap cycle = tick with counter at max.
REQ-017 SHALL assert period_o for exactly the wrap cycle.
REQ-018 SHALL enable LED k when pwm_cnt < active duty k; duty 0 → never on; duty max → on (2^PWM_W-1)/2^PWM_W of period.
REQ-019 SHALL drive rgb_o from a register updated every cycle: rgb_o[k] = decoded colour AND enable AND blink gate; latency 1 clk from counter state.
REQ-020 SHALL on load_i capture all inputs into pending registers and set pending flag; load_i while pending overwrites pending values (last wins), single ack.
REQ-021 SHALL copy pending to active registers only in wrap cycle, clear pending, and pulse load_ack_o the following cycle; settings never change mid-period.
REQ-022 SHALL, when load_i coincides with wrap cycle, apply previously pending values (if any) and keep new values pending for next wrap.
REQ-023 SHALL count wraps 0..BLINK_PER-1 and toggle blink phase at each count rollover; phase starts "on".
REQ-024 SHALL force LED k off during "off" phase when active blink k = 1; non-blink LEDs unaffected.

Reset
REQ-025 SHALL on rst_n low immediately clear prescaler, PWM counter, blink counter, pending flag, rgb_o, load_ack_o, period_o to 0.
REQ-026 SHALL reset active colour to 111 (off), active duty 0, active blink 0, blink phase "on"; reset mid-period discards pending load without ack.

Configuration
REQ-027 SHALL support macro RGB_PWM_BLINK_EN: defined → REQ-023/024 implemented; undefined → blink counter/phase absent, blink_i ignored, gate constant 1.

Structure
REQ-028 SHALL place colour-code constants (3-bit codes, {R,G,B} patterns) and decode function in shared package rgb_pkg.
REQ-029 SHALL instantiate one sub-module rgb_pwm_chan per LED (duty compare, colour decode, blink gate, output register); timebase and load logic stay in top.

Verification (PRESC=2, PWM_W=4, BLINK_PER=2, N_LED=2)
REQ-030 SHALL cover reset: after rst_n release, load none → rgb_o=000000, period_o pulses every 32 clk.
REQ-031 SHALL cover duty: load color 110, duty 4 on LED0 → after ack, LED0 = 111 for 8 clk of each 32-clk period, else 000.
REQ-032 SHALL cover extremes: duty 0 → LED always 000; duty 15 → on 30 of 32 clk.
REQ-033 SHALL cover load timing: load_i mid-period → rgb_o unchanged until wrap, load_ack_o exactly 1 clk after period_o; two loads in one period → one ack, last values active.
REQ-034 SHALL cover blink (macro defined): blink_i=01, duty 15 → LED0 on 2 periods, off 2 periods; LED1 steady.
REQ-035 SHALL cover async reset mid-period with pending load: rgb_o=0 within same cycle, no load_ack_o afterwards.
